// File: rtl/l2_mem_responder_pkg.sv
// Shared widths, defaults and FSM encoding for the L2 block-memory responder.
package l2_mem_responder_pkg;

   localparam int ADDR_W             = 28;
   localparam int DATA_W             = 128;
   localparam int CNT_W              = 4;
   localparam int DEFAULT_LATENCY    = 4;
   localparam int DEFAULT_DEPTH_LOG2 = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

endpackage

// File: rtl/l2_mem_responder_mem_block_array.sv
// Block storage: one synchronous write port, one enabled registered read port.
// Only the read register is reset; the array contents are left untouched.
module mem_block_array #(
   parameter int DEPTH_LOG2 = 10,
   parameter int DATA_W     = 128
) (
   input  logic                  clk,
   input  logic                  i_srst,
   input  logic                  i_we,
   input  logic [DEPTH_LOG2-1:0] i_waddr,
   input  logic [DATA_W-1:0]     i_wdata,
   input  logic                  i_re,
   input  logic [DEPTH_LOG2-1:0] i_raddr,
   output logic [DATA_W-1:0]     o_rdata
);

   logic [DATA_W-1:0] r_mem [0:(1 << DEPTH_LOG2)-1];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // The read register only moves on an enabled read, so it holds between reads.
   always_ff @(posedge clk) begin
      if (i_srst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/l2_mem_responder.sv
// Single-outstanding block read/write responder with a fixed request-to-ready latency.
// Storage is accessed on the edge that enters RESP, so data and ready appear together.
module l2_mem_responder
   import l2_mem_responder_pkg::*;
#(
   parameter int LATENCY    = DEFAULT_LATENCY,
   parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
   input  logic              clk,
   input  logic              proc_reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready
);

   localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LATENCY - 1);

   state_e                r_state;
   state_e                w_state_next;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_next;
   logic                  r_op_wr;
   logic                  w_op_wr_next;
   logic [DEPTH_LOG2-1:0] r_idx;
   logic [DEPTH_LOG2-1:0] w_idx_next;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W-1:0]     w_wdata_next;
   logic                  r_ready;

   logic                  w_to_resp;
   logic                  w_mem_we;
   logic                  w_mem_re;
   logic                  w_unused_addr_hi;

   // Upper address bits alias away; reduce them so they are visibly consumed.
   assign w_unused_addr_hi = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_op_wr_next = r_op_wr;
      w_idx_next   = r_idx;
      w_wdata_next = r_wdata;
      case (r_state)
         ST_IDLE: begin
            if (mem_read ^ mem_write) begin
               w_op_wr_next = mem_write;
               w_idx_next   = mem_addr[DEPTH_LOG2-1:0];
               w_wdata_next = mem_wdata;
               w_cnt_next   = LOAD_CNT;
               w_state_next = (LATENCY == 1) ? ST_RESP : ST_BUSY;
            end
         end
         ST_BUSY: begin
            w_cnt_next = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: w_state_next = ST_HOLD;
         ST_HOLD: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Using the next-latched values lets a LATENCY=1 accept hit storage directly.
   assign w_to_resp = (w_state_next == ST_RESP) && !proc_reset;
   assign w_mem_we  = w_to_resp && w_op_wr_next;
   assign w_mem_re  = w_to_resp && !w_op_wr_next;

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_op_wr <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_op_wr <= w_op_wr_next;
         r_idx   <= w_idx_next;
         r_wdata <= w_wdata_next;
         r_ready <= (w_state_next == ST_RESP);
      end
   end

   mem_block_array #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DATA_W     (DATA_W)
   ) u_mem (
      .clk     (clk),
      .i_srst  (proc_reset),
      .i_we    (w_mem_we),
      .i_waddr (w_idx_next),
      .i_wdata (w_wdata_next),
      .i_re    (w_mem_re),
      .i_raddr (w_idx_next),
      .o_rdata (mem_rdata)
   );

   assign mem_ready = r_ready;

endmodule

// File: doc/l2_mem_responder.md
L2_MEM_RESPONDER -- requirements
Module: l2_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to mem_ready pulse; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10: log2 of stored 128-bit blocks.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port proc_reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port mem_read  input  1  block read request; level, held by requester until it observes mem_ready.
REQ-006 SHALL have port mem_write  input  1  block write request; level, same holding rule.
REQ-007 SHALL have port mem_addr  input  28  block address (16-byte granule).
REQ-008 SHALL have port mem_wdata  input  128  write block data.
REQ-009 SHALL have port mem_rdata  output  128  read block data, registered.
REQ-010 SHALL have port mem_ready  output  1  one-cycle completion pulse, registered.

Function
REQ-011 SHALL implement the FSM states IDLE, BUSY, RESP and HOLD.
REQ-012 In IDLE, exactly one of mem_read/mem_write high SHALL be accepted: latch op, mem_addr[DEPTH_LOG2-1:0], mem_wdata; load counter with LATENCY-1; go BUSY (or RESP directly if LATENCY=1).
REQ-013 mem_read and mem_write both high in IDLE SHALL be ignored (no acceptance, state stays IDLE).
REQ-014 In BUSY the counter SHALL decrement each cycle; at 0 go RESP; input changes (addr, data, request drop) during BUSY SHALL be ignored and the latched operation SHALL complete.
REQ-015 In RESP, mem_ready SHALL be 1 for exactly that cycle; a latched write SHALL commit the latched data to storage; a latched read SHALL load mem_rdata from storage at the latched index.
REQ-016 Accepted at cycle t, mem_ready SHALL be high in cycle t+LATENCY exactly.
REQ-017 HOLD SHALL last exactly one cycle after RESP, ignore all requests, then return to IDLE: the requester samples mem_ready through a register and still drives the old request during this cycle.
REQ-018 mem_rdata SHALL hold its value from RESP until the next read's RESP; writes SHALL NOT change mem_rdata.
REQ-019 Address bits above DEPTH_LOG2-1 SHALL be discarded; addresses alias modulo 2^DEPTH_LOG2 blocks.
REQ-020 Counter width SHALL be 4 bits; no wrap occurs within the legal LATENCY range.
REQ-021 Only one outstanding request SHALL exist; no queuing.
REQ-022 A read of a block written earlier SHALL return the committed data (write visible from the cycle after its RESP).

Reset
REQ-023 proc_reset high SHALL force state IDLE, counter 0, mem_ready 0, mem_rdata 0, and latched op/addr/data 0 on the next rising edge.
REQ-024 Reset during BUSY or RESP SHALL abort the operation; an aborted write SHALL NOT commit unless its RESP edge already occurred.
REQ-025 Storage contents SHALL NOT be reset.
REQ-026 A request present in the first cycle after reset deasserts SHALL be accepted.

Structure
REQ-027 Shared package SHALL hold ADDR_W=28, DATA_W=128, the FSM state encoding, and default LATENCY.
REQ-028 Storage SHALL be a sub-module mem_block_array: one synchronous write port, one read port, 2^DEPTH_LOG2 x 128 bits.
REQ-029 FSM, counter and latches SHALL reside in l2_mem_responder.

Verification
REQ-030 Write addr 0x0000005, data 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 held, LATENCY=4 -> mem_ready high 4 cycles after acceptance, 1 cycle wide; mem_rdata stays 0.
REQ-031 Read of addr 0x0000005 afterward -> mem_ready at t+4 with mem_rdata equal to written data, held until next read completes.
REQ-032 Request held for one cycle after mem_ready (registered-ready requester) -> no second acceptance; next new request accepted 2 cycles after RESP.
REQ-033 mem_addr changed from 0x05 to 0x09 and mem_read dropped mid-BUSY -> completion at t+4 uses index 0x05.
REQ-034 Write 0xAA.. to addr 0x0000405 (DEPTH_LOG2=10), read addr 0x0000005 -> returns 0xAA.. (alias); read+write both high in IDLE -> no mem_ready for 20 cycles.
REQ-035 proc_reset asserted during BUSY of write to 0x07 -> mem_ready 0, state IDLE next cycle; subsequent read of 0x07 returns prior content.
